// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and helpers for the instruction-fetch front end
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP              = 32'h0000_0013;

  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous in-order FIFO with flush, used for PC tags and the instruction queue
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  input  logic                          flush,
  output logic [WIDTH-1:0]              head_data,
  output logic                          full,
  output logic                          empty,
  output logic [cnt_width(DEPTH)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // Storage is left as-is; only the pointers define what is live.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/imem_fetch_queue.sv
// rtl/imem_fetch_queue.sv - sequential fetch engine with redirect flush; IMEM_BYTESWAP_EN swaps fetched bytes
module imem_fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int CW = cnt_width(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;

  logic [CW+1:0] budget;
  logic          gnt_fire, live_rsp, q_pop;
  logic [31:0]   rsp_data, tag_pc;
  logic [63:0]   q_head;
  logic          q_full, q_empty, tag_full, tag_empty;
  logic [CW-1:0] q_count, tag_count;
  logic          unused_ok;

  assign unused_ok = ^redirect_pc[1:0];

  // Stale fetches still occupy a memory slot, so they consume credit too.
  assign budget   = {2'b00, q_count} + {2'b00, outstanding_q} + {2'b00, discard_q};
  assign mem_req  = rst_n && !redirect_valid && (budget < (CW+2)'(DEPTH));
  assign mem_addr = fetch_pc_q;
  assign gnt_fire = mem_req && mem_gnt;

  assign live_rsp = mem_rvalid && (discard_q == '0) && !redirect_valid;
  assign q_pop    = inst_valid && inst_ready && !redirect_valid;

`ifdef IMEM_BYTESWAP_EN
  assign rsp_data = byte_swap(mem_rdata);
`else
  assign rsp_data = mem_rdata;
`endif

  assign inst_valid = !q_empty;
  assign inst_data  = q_head[63:32];
  assign inst_pc    = q_head[31:0];

  fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (gnt_fire),
    .push_data (fetch_pc_q),
    .pop       (mem_rvalid),
    .flush     (1'b0),
    .head_data (tag_pc),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );

  fetch_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_inst_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (live_rsp),
    .push_data ({rsp_data, tag_pc}),
    .pop       (q_pop),
    .flush     (redirect_valid),
    .head_data (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    if (redirect_valid) begin
      // Everything still in flight becomes stale.
      discard_d     = discard_q + outstanding_q + CW'(gnt_fire) - CW'(mem_rvalid);
      outstanding_d = '0;
      fetch_pc_d    = {redirect_pc[31:2], 2'b00};
    end else begin
      if (gnt_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (mem_rvalid && (discard_q != '0)) begin
        discard_d = discard_q - CW'(1);
      end
      outstanding_d = outstanding_q + CW'(gnt_fire)
                    - CW'(mem_rvalid && (discard_q == '0));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  a_no_queue_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(live_rsp && q_full && !q_pop));
  a_rsp_has_tag: assert property (@(posedge clk) disable iff (!rst_n)
    !(mem_rvalid && tag_empty));
  a_tag_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(gnt_fire && tag_full));
  a_tag_tracks_inflight: assert property (@(posedge clk) disable iff (!rst_n)
    ({1'b0, tag_count} == {1'b0, outstanding_q} + {1'b0, discard_q}));

endmodule
